ras_ctrl: RTL and testbench

- Speculation/repair controller for the return-address stack (RAS).
- Decode drives speculative pushes (calls: jal/jalr with rd in {x1,x5}) and pops (returns: jalr, rs1 in {x1,x5}, rd not a link register). Each one checkpoints the stack pointer and top-of-stack (TOS) contents.
- Execute resolves operations in program order. On a mispredict, the controller restores the oldest checkpoint and replays the correct architectural action.
- Owns the circular stack storage and drives the return prediction back to fetch/decode.

---
 rtl/ras_pkg.sv | 28 ++
 rtl/ras_ckpt_fifo.sv | 55 +++++
 rtl/ras_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_ras_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ras_pkg.sv
// Shared types and widths for the return-address-stack controller.
// RAS_RECURSION_CNT_EN adds a per-entry repeat counter to checkpoints.
package ras_pkg;

    localparam int unsigned RAS_DEPTH      = 8;
    localparam int unsigned RAS_CKPT_DEPTH = 4;
    localparam int unsigned RAS_XLEN       = 32;

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    // Occupancy spans 0..DEPTH inclusive, so one bit wider than the pointer.
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;
    localparam int unsigned REP_W = 3;

    typedef struct packed {
        logic [PTR_W-1:0]    tos;
        logic [CNT_W-1:0]    count;
        logic [RAS_XLEN-1:0] top;
`ifdef RAS_RECURSION_CNT_EN
        logic [REP_W-1:0]    top_cnt;
`endif
    } ras_ckpt_t;

    typedef enum logic [0:0] {
        RAS_RUN,
        RAS_RECOVER
    } ras_state_e;

endpackage

// File: rtl/ras_ckpt_fifo.sv
// Checkpoint FIFO for speculative RAS operations; flush wins over enq.
module ras_ckpt_fifo
    import ras_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_CKPT_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      enq,
    input  logic      deq,
    input  logic      flush,
    input  ras_ckpt_t enq_data,
    output ras_ckpt_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   occ_q;
    ras_ckpt_t     mem_q [DEPTH];
    logic          do_enq, do_deq;

    assign full   = (occ_q == (PW+1)'(DEPTH));
    assign empty  = (occ_q == '0);
    assign head   = mem_q[rptr_q];
    assign do_enq = enq && !full && !flush;
    assign do_deq = deq && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            if (do_enq) wptr_q <= wptr_q + PW'(1);
            if (do_deq) rptr_q <= rptr_q + PW'(1);
            case ({do_enq, do_deq})
                2'b10:   occ_q <= occ_q + (PW+1)'(1);
                2'b01:   occ_q <= occ_q - (PW+1)'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem_q[wptr_q] <= enq_data;
    end

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack speculation/repair controller with in-order checkpoint recovery.
// Define RAS_RECURSION_CNT_EN to fold repeated pushes of the same address into a counter.
module ras_ctrl
    import ras_pkg::*;
#(
    // Overrides must be mirrored in ras_pkg, which sizes the checkpoint fields.
    parameter int unsigned DEPTH      = RAS_DEPTH,
    parameter int unsigned CKPT_DEPTH = RAS_CKPT_DEPTH,
    parameter int unsigned XLEN       = RAS_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            spec_push,
    input  logic            spec_pop,
    input  logic [XLEN-1:0] spec_addr,
    input  logic            resolve_valid,
    input  logic            resolve_mispredict,
    input  logic            fix_push,
    input  logic            fix_pop,
    input  logic [XLEN-1:0] fix_addr,
    output logic            pred_valid,
    output logic [XLEN-1:0] pred_target,
    output logic            empty,
    output logic            ckpt_full,
    output logic            busy
);

    ras_state_e       state_q, state_d;
    logic [PTR_W-1:0] tos_q, tos_d, tos_inc, tos_dec;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  stack_q [DEPTH];

    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [XLEN-1:0]  wr_data;

    ras_ckpt_t ckpt_in, ckpt_head;
    logic      fifo_full, fifo_empty;
    logic      in_run, mispredict, accept, deq;
    logic      op_en, op_push, op_pop;
    logic [XLEN-1:0] op_addr;
    logic      do_push, do_swap, do_pop, rep_hit, rep_nz, stack_full;

`ifdef RAS_RECURSION_CNT_EN
    logic [REP_W-1:0] rep_q [DEPTH];
    logic             rep_we;
    logic [PTR_W-1:0] rep_idx;
    logic [REP_W-1:0] rep_data, top_rep;

    assign top_rep = rep_q[tos_q];
    assign rep_hit = (count_q != '0) && (op_addr == stack_q[tos_q]);
    assign rep_nz  = (top_rep != '0);
`else
    assign rep_hit = 1'b0;
    assign rep_nz  = 1'b0;
`endif

    assign in_run     = (state_q == RAS_RUN);
    // A mispredict with nothing outstanding has no checkpoint to restore from.
    assign mispredict = in_run && resolve_valid && resolve_mispredict && !fifo_empty;
    assign accept     = in_run && (spec_push || spec_pop) && !stall && !fifo_full &&
                        !(resolve_valid && resolve_mispredict);
    assign deq        = in_run && resolve_valid && !resolve_mispredict;

    // RUN applies accepted decode ops; RECOVER applies the architectural fix.
    assign op_en   = in_run ? accept : 1'b1;
    assign op_push = in_run ? spec_push : fix_push;
    assign op_pop  = in_run ? spec_pop : fix_pop;
    assign op_addr = in_run ? spec_addr : fix_addr;

    assign do_push    = op_push && (!op_pop || count_q == '0);
    assign do_swap    = op_push && op_pop && count_q != '0;
    assign do_pop     = op_pop && !op_push && count_q != '0;
    assign tos_inc    = tos_q + PTR_W'(1);
    assign tos_dec    = tos_q - PTR_W'(1);
    assign stack_full = (count_q == CNT_W'(DEPTH));

    always_comb begin
        ckpt_in.tos   = tos_q;
        ckpt_in.count = count_q;
        ckpt_in.top   = stack_q[tos_q];
`ifdef RAS_RECURSION_CNT_EN
        ckpt_in.top_cnt = top_rep;
`endif
    end

    ras_ckpt_fifo #(
        .DEPTH (CKPT_DEPTH)
    ) u_ckpt_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .enq      (accept),
        .deq      (deq),
        .flush    (mispredict),
        .enq_data (ckpt_in),
        .head     (ckpt_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RAS_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RAS_RUN:     if (mispredict) state_d = RAS_RECOVER;
            RAS_RECOVER: state_d = RAS_RUN;
            default:     state_d = RAS_RUN;
        endcase
    end

    always_comb begin
        pred_target = stack_q[tos_q];
        pred_valid  = in_run && (count_q != '0);
        empty       = (count_q == '0);
        ckpt_full   = fifo_full;
        busy        = (state_q == RAS_RECOVER);
    end

    always_comb begin
        tos_d   = tos_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = tos_q;
        wr_data = op_addr;
`ifdef RAS_RECURSION_CNT_EN
        rep_we   = 1'b0;
        rep_idx  = tos_q;
        rep_data = '0;
`endif
        if (mispredict) begin
            tos_d   = ckpt_head.tos;
            count_d = ckpt_head.count;
            wr_en   = 1'b1;
            wr_idx  = ckpt_head.tos;
            wr_data = ckpt_head.top;
`ifdef RAS_RECURSION_CNT_EN
            rep_we   = 1'b1;
            rep_idx  = ckpt_head.tos;
            rep_data = ckpt_head.top_cnt;
`endif
        end else if (op_en) begin
            if (do_push && rep_hit) begin
`ifdef RAS_RECURSION_CNT_EN
                rep_we   = 1'b1;
                rep_data = (top_rep == '1) ? top_rep : top_rep + REP_W'(1);
`endif
            end else if (do_push) begin
                tos_d   = tos_inc;
                count_d = stack_full ? count_q : count_q + CNT_W'(1);
                wr_en   = 1'b1;
                wr_idx  = tos_inc;
`ifdef RAS_RECURSION_CNT_EN
                rep_we  = 1'b1;
                rep_idx = tos_inc;
`endif
            end else if (do_swap) begin
                wr_en = 1'b1;
`ifdef RAS_RECURSION_CNT_EN
                rep_we = 1'b1;
`endif
            end else if (do_pop && rep_nz) begin
`ifdef RAS_RECURSION_CNT_EN
                rep_we   = 1'b1;
                rep_data = top_rep - REP_W'(1);
`endif
            end else if (do_pop) begin
                tos_d   = tos_dec;
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
            if (wr_en) stack_q[wr_idx] <= wr_data;
        end
    end

`ifdef RAS_RECURSION_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) rep_q[i] <= '0;
        end else if (rep_we) begin
            rep_q[rep_idx] <= rep_data;
        end
    end
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: a stack/queue model checked every cycle plus literal spot checks.
module tb_ras_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, spec_push, spec_pop, resolve_valid, resolve_mispredict;
    logic        fix_push, fix_pop;
    logic [31:0] spec_addr, fix_addr;
    logic        pred_valid, empty, ckpt_full, busy;
    logic [31:0] pred_target;

    ras_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall              (stall),
        .spec_push          (spec_push),
        .spec_pop           (spec_pop),
        .spec_addr          (spec_addr),
        .resolve_valid      (resolve_valid),
        .resolve_mispredict (resolve_mispredict),
        .fix_push           (fix_push),
        .fix_pop            (fix_pop),
        .fix_addr           (fix_addr),
        .pred_valid         (pred_valid),
        .pred_target        (pred_target),
        .empty              (empty),
        .ckpt_full          (ckpt_full),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain array stack, a queue of snapshots and a recovery flag.
    typedef struct {
        int          tos;
        int          count;
        logic [31:0] top;
        int          rep;
    } snap_t;

    logic [31:0] m_stack [8];
    int          m_rep   [8];
    int          m_tos, m_count;
    snap_t       m_q [$];
    bit          m_recover, m_kill, m_acc;
    snap_t       m_s;

    task automatic m_apply(input bit push, input bit pop, input logic [31:0] addr);
        if (push && (!pop || m_count == 0)) begin
`ifdef RAS_RECURSION_CNT_EN
            if (m_count > 0 && addr == m_stack[m_tos]) begin
                if (m_rep[m_tos] < 7) m_rep[m_tos]++;
                return;
            end
`endif
            m_tos          = (m_tos + 1) % 8;
            m_stack[m_tos] = addr;
            m_rep[m_tos]   = 0;
            if (m_count < 8) m_count++;
        end else if (push && pop) begin
            m_stack[m_tos] = addr;
            m_rep[m_tos]   = 0;
        end else if (pop && m_count > 0) begin
            if (m_rep[m_tos] > 0) begin
                m_rep[m_tos]--;
            end else begin
                m_tos = (m_tos + 7) % 8;
                m_count--;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_stack[i] = '0;
                m_rep[i]   = 0;
            end
            m_tos     = 0;
            m_count   = 0;
            m_recover = 1'b0;
            m_q.delete();
        end else if (m_recover) begin
            m_apply(fix_push, fix_pop, fix_addr);
            m_recover = 1'b0;
        end else begin
            m_kill = resolve_valid && resolve_mispredict;
            m_acc  = (spec_push || spec_pop) && !stall && (m_q.size() < 4) && !m_kill;
            if (m_kill && m_q.size() > 0) begin
                m_s              = m_q[0];
                m_tos            = m_s.tos;
                m_count          = m_s.count;
                m_stack[m_s.tos] = m_s.top;
                m_rep[m_s.tos]   = m_s.rep;
                m_q.delete();
                m_recover = 1'b1;
            end else if (!m_kill) begin
                if (resolve_valid && m_q.size() > 0) m_q.pop_front();
                if (m_acc) begin
                    m_q.push_back('{m_tos, m_count, m_stack[m_tos], m_rep[m_tos]});
                    m_apply(spec_push, spec_pop, spec_addr);
                end
            end
        end
    end

    always @(negedge clk) begin
        check("pred_valid", 32'(pred_valid), 32'(!m_recover && m_count != 0));
        check("pred_target", pred_target, m_stack[m_tos]);
        check("empty", 32'(empty), 32'(m_count == 0));
        check("ckpt_full", 32'(ckpt_full), 32'(m_q.size() == 4));
        check("busy", 32'(busy), 32'(m_recover));
    end

    task automatic tick();
        @(posedge clk);
        #1;
        stall              = 1'b0;
        spec_push          = 1'b0;
        spec_pop           = 1'b0;
        resolve_valid      = 1'b0;
        resolve_mispredict = 1'b0;
        fix_push           = 1'b0;
        fix_pop            = 1'b0;
    endtask

    task automatic push(input logic [31:0] a);
        spec_push = 1'b1;
        spec_addr = a;
        tick();
    endtask

    task automatic pop();
        spec_pop = 1'b1;
        tick();
    endtask

    task automatic resolve();
        resolve_valid = 1'b1;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pv"}, 32'(pred_valid), 32'd0);
        check({tag, "_pt"}, pred_target, 32'h0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(ckpt_full), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Pulse reset between clock edges; called just after tick().
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; spec_push = 1'b0; spec_pop = 1'b0; spec_addr = '0;
        resolve_valid = 1'b0; resolve_mispredict = 1'b0;
        fix_push = 1'b0; fix_pop = 1'b0; fix_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Basic push/pop, plus a stalled push that must be ignored.
        push(32'h100);
        push(32'h200);
        check("t1_top", pred_target, 32'h200);
        check("t1_valid", 32'(pred_valid), 32'd1);
        stall = 1'b1;
        push(32'h999);
        check("t1_stall", pred_target, 32'h200);
        pop();
        check("t1_pop", pred_target, 32'h100);
        check("t1_nonempty", 32'(empty), 32'd0);
        repeat (3) resolve();

        // Overflow wraps onto the oldest entry.
        pulse_reset("rst2");
        tick();
        for (int i = 1; i <= 9; i++) begin
            push(32'(i * 16));
            resolve();
        end
        check("t2_top", pred_target, 32'h90);
        for (int k = 0; k < 8; k++) begin
            check("t2_popseq", pred_target, 32'(32'h90 - 16 * k));
            check("t2_notempty", 32'(empty), 32'd0);
            pop();
            resolve();
        end
        check("t2_empty", 32'(empty), 32'd1);

        // Mispredicted pop repaired by a push.
        pulse_reset("rst3");
        tick();
        push(32'h100);
        resolve();
        pop();
        resolve_valid = 1'b1;
        resolve_mispredict = 1'b1;
        tick();
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_pv", 32'(pred_valid), 32'd0);
        fix_push = 1'b1;
        fix_addr = 32'h300;
        tick();
        check("t3_fix", pred_target, 32'h300);
        check("t3_run", 32'(busy), 32'd0);
        pop();
        check("t3_below", pred_target, 32'h100);
        resolve();

        // Checkpoint FIFO full handling.
        pulse_reset("rst4");
        tick();
        push(32'h410);
        push(32'h420);
        push(32'h430);
        push(32'h440);
        check("t4_full", 32'(ckpt_full), 32'd1);
        push(32'h500);
        check("t4_ignored", pred_target, 32'h440);
        check("t4_still_full", 32'(ckpt_full), 32'd1);
        resolve();
        check("t4_notfull", 32'(ckpt_full), 32'd0);
        resolve_valid = 1'b1;
        push(32'h450);
        check("t4_same_occ", 32'(ckpt_full), 32'd0);
        check("t4_top", pred_target, 32'h450);
        push(32'h460);
        check("t4_refull", 32'(ckpt_full), 32'd1);

        // Mispredict discards a same-cycle push; reset aborts recovery.
        pulse_reset("rst5");
        tick();
        push(32'h600);
        resolve();
        push(32'h610);
        check("t5_spec", pred_target, 32'h610);
        resolve_valid = 1'b1;
        resolve_mispredict = 1'b1;
        push(32'h700);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_restored", pred_target, 32'h600);
        pulse_reset("rst_recover");
        tick();
        tick();

`ifdef RAS_RECURSION_CNT_EN
        // Repeated identical pushes collapse into one counted entry.
        push(32'h40);
        resolve();
        push(32'h40);
        resolve();
        push(32'h40);
        resolve();
        check("t6_top", pred_target, 32'h40);
        pop();
        pop();
        check("t6_still", 32'(empty), 32'd0);
        check("t6_top2", pred_target, 32'h40);
        pop();
        check("t6_empty", 32'(empty), 32'd1);
        repeat (3) resolve();
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
